// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential calculator.
package calc_pkg;

    // Operation codes, encoded exactly as driven on the op input.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ACC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [6:0] SEG7 [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; no state.
    always_comb begin
        seg = SEG7[nibble];
    end

endmodule

// File: rtl/seq_calculator.sv
// Sequential ADD/SUB/MUL/ACC calculator with registered result and hex display.
module seq_calculator
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [1:0]             op,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     result,
    output logic                   neg,
    output logic                   ovf,
    output logic [7*(WIDTH/2)-1:0] hex
);

    localparam int unsigned RW     = 2 * WIDTH;
    localparam int unsigned DIGITS = RW / 4;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    op_e                op_q;
    logic [RW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [RW-1:0]      prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RW-1:0]      result_q;
    logic               neg_q, ovf_q, done_q;

    logic [RW-1:0]      a_ext, b_ext;
    logic [RW:0]        acc_sum;
    logic [RW-1:0]      op_result;
    logic               op_neg, op_ovf;

    assign a_ext = {{WIDTH{1'b0}}, a_q};
    assign b_ext = {{WIDTH{1'b0}}, b_q};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: MUL iterates WIDTH cycles, every op finishes through DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (op_e'(op) == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Result of the latched operation; ACC folds in the current result register.
    always_comb begin
        acc_sum   = {1'b0, result_q} + {1'b0, a_ext};
        op_result = '0;
        op_neg    = 1'b0;
        op_ovf    = 1'b0;
        case (op_q)
            OP_ADD: op_result = a_ext + b_ext;
            OP_SUB: begin
                op_result = a_ext - b_ext;
                op_neg    = (a_q < b_q);
            end
            OP_MUL: op_result = prod_q;
            OP_ACC: begin
                op_result = acc_sum[RW-1:0];
                op_ovf    = acc_sum[RW];
            end
            default: op_result = '0;
        endcase
    end

    // Datapath: operand latch, shift-add multiplier, result write with one-cycle done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op_e'(op);
                        mcand_q  <= {{WIDTH{1'b0}}, a};
                        mplier_q <= b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    result_q <= op_result;
                    neg_q    <= op_neg;
                    ovf_q    <= op_ovf;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;
    assign done   = done_q;

    // One decoder per displayed nibble, digit 0 = least significant.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        hex_to_seg7 u_seg (
            .nibble (result_q[4*i +: 4]),
            .seg    (hex[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator at WIDTH=4 and WIDTH=8.
module tb_seq_calculator;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] ACC = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  a4, b4;
    logic [1:0]  op4;
    logic        start4, busy4, done4, neg4, ovf4;
    logic [7:0]  res4;
    logic [13:0] hex4;

    logic [7:0]  a8, b8;
    logic [1:0]  op8;
    logic        start8, busy8, done8, neg8, ovf8;
    logic [15:0] res8;
    logic [27:0] hex8;

    int vectors = 0;
    int miscompares = 0;

    // Model state: last completed result per instance (ACC source).
    logic [31:0] last4, last8;

    logic        sel8;
    logic        obs_busy, obs_done, obs_neg, obs_ovf;
    logic [15:0] obs_res;
    logic [27:0] obs_hex;

    seq_calculator #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .a      (a4),
        .b      (b4),
        .op     (op4),
        .start  (start4),
        .busy   (busy4),
        .done   (done4),
        .result (res4),
        .neg    (neg4),
        .ovf    (ovf4),
        .hex    (hex4)
    );

    seq_calculator #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .a      (a8),
        .b      (b8),
        .op     (op8),
        .start  (start8),
        .busy   (busy8),
        .done   (done8),
        .result (res8),
        .neg    (neg8),
        .ovf    (ovf8),
        .hex    (hex8)
    );

    always_comb begin
        if (sel8) begin
            obs_busy = busy8; obs_done = done8; obs_neg = neg8; obs_ovf = ovf8;
            obs_res  = res8;  obs_hex  = hex8;
        end else begin
            obs_busy = busy4; obs_done = done4; obs_neg = neg4; obs_ovf = ovf4;
            obs_res  = {8'h00, res4};
            obs_hex  = {14'h0, hex4};
        end
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] hex_ref(input int w, input logic [31:0] v);
        logic [27:0] h;
        h = '0;
        for (int i = 0; i < w / 2; i++) h[7*i +: 7] = seg_ref(v[4*i +: 4]);
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w8, input logic [1:0] o, input logic [15:0] av,
                         input logic [15:0] bv, input logic st);
        if (w8) begin
            a8 = av[7:0]; b8 = bv[7:0]; op8 = o; start8 = st;
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; op4 = o; start4 = st;
        end
    endtask

    // Issue one op, optionally hammering start while busy, and check the outcome.
    task automatic run_op(input logic w8, input logic [1:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input bit poke);
        int          w, lat, n;
        logic [31:0] wmask, mask, am, bm, last, sum, exp_res;
        logic        exp_neg, exp_ovf;
        w     = w8 ? 8 : 4;
        wmask = (32'd1 << w) - 32'd1;
        mask  = (32'd1 << (2 * w)) - 32'd1;
        am    = {16'h0, av} & wmask;
        bm    = {16'h0, bv} & wmask;
        last  = w8 ? last8 : last4;
        exp_neg = 1'b0;
        exp_ovf = 1'b0;
        case (o)
            ADD: exp_res = am + bm;
            SUB: begin exp_res = (am - bm) & mask; exp_neg = (am < bm); end
            MUL: exp_res = am * bm;
            default: begin
                sum     = last + am;
                exp_res = sum & mask;
                exp_ovf = (sum > mask);
            end
        endcase
        lat  = (o == MUL) ? w + 1 : 1;
        sel8 = w8;

        @(negedge clk);
        drive(w8, o, av, bv, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(w8, o, av, bv, 1'b0);
        n = 0;
        while (obs_done !== 1'b1 && n < lat + 4) begin
            chk("busy_during_op", {31'b0, obs_busy}, 32'd1);
            if (poke) drive(w8, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        drive(w8, o, av, bv, 1'b0);
        chk("latency", n, lat);
        chk("done", {31'b0, obs_done}, 32'd1);
        chk("result", {16'h0, obs_res}, exp_res);
        chk("neg", {31'b0, obs_neg}, {31'b0, exp_neg});
        chk("ovf", {31'b0, obs_ovf}, {31'b0, exp_ovf});
        chk("hex", {4'h0, obs_hex}, {4'h0, hex_ref(w, exp_res)});
        chk("busy_at_done", {31'b0, obs_busy}, 32'd0);
        if (w8) last8 = exp_res; else last4 = exp_res;
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, obs_done}, 32'd0);
        chk("idle_after_done", {31'b0, obs_busy}, 32'd0);
        chk("result_held", {16'h0, obs_res}, exp_res);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy4", {31'b0, busy4}, 32'd0);
        chk("rst_done4", {31'b0, done4}, 32'd0);
        chk("rst_result4", {24'h0, res4}, 32'd0);
        chk("rst_hex4", {18'h0, hex4}, {4'h0, hex_ref(4, 32'd0)});
        chk("rst_result8", {16'h0, res8}, 32'd0);
        chk("rst_hex8", {4'h0, hex8}, {4'h0, hex_ref(8, 32'd0)});
        chk("rst_flags", {30'b0, neg4, ovf4}, 32'd0);
        last4 = '0;
        last8 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        sel8 = 1'b0;
        drive(1'b0, ADD, 16'h0, 16'h0, 1'b0);
        drive(1'b1, ADD, 16'h0, 16'h0, 1'b0);
        last4 = '0;
        last8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while idle.
        do_reset();

        // Directed WIDTH=4 cases.
        run_op(1'b0, ADD, 16'h3, 16'h2, 1'b0);
        chk("add_const", {24'h0, res4}, 32'h05);
        run_op(1'b0, SUB, 16'h3, 16'h5, 1'b0);
        chk("sub_const", {24'h0, res4}, 32'hFE);
        run_op(1'b0, MUL, 16'hF, 16'hF, 1'b1);
        chk("mul_const", {24'h0, res4}, 32'hE1);
        chk("mul_hex_const", {18'h0, hex4}, {18'h0, 7'b0000110, 7'b1111001});

        // Accumulator wrap.
        do_reset();
        for (int i = 0; i < 17; i++) run_op(1'b0, ACC, 16'hF, 16'($urandom), 1'b0);
        chk("acc17_const", {23'h0, ovf4, res4}, 32'h0FF);
        run_op(1'b0, ACC, 16'hF, 16'h0, 1'b0);
        chk("acc18_const", {23'h0, ovf4, res4}, 32'h10E);

        // Reset two cycles into a multiply: abort, no done pulse.
        sel8 = 1'b0;
        @(negedge clk);
        drive(1'b0, MUL, 16'hF, 16'hF, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, MUL, 16'hF, 16'hF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy4}, 32'd0);
        chk("abort_result", {24'h0, res4}, 32'd0);
        chk("abort_done", {31'b0, done4}, 32'd0);
        last4 = '0;
        last8 = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done4}, 32'd0);
        end
        run_op(1'b0, ADD, 16'hE, 16'h1, 1'b0);
        chk("post_abort_add", {24'h0, res4}, 32'h0F);

        // Directed WIDTH=8 repeats.
        run_op(1'b1, ADD, 16'h3, 16'h2, 1'b0);
        run_op(1'b1, SUB, 16'h3, 16'h5, 1'b0);
        run_op(1'b1, MUL, 16'hFF, 16'hFF, 1'b1);

        // Randomized mix on both widths.
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
